// File: rtl/model_stream_loader.sv
// Quantized model weight stream loader: parses per-layer headers and weights from a byte stream into weight RAM.
// Optional trailing XOR checksum byte is enabled by defining MODEL_CHECKSUM_EN.
module model_stream_loader #(
  parameter int MAX_LAYERS   = 10,
  parameter int MAX_NEURONS  = 1024,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_load,
  input  logic [7:0]              num_layers,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    layer_hdr_valid,
  output logic [7:0]              layer_idx,
  output logic [31:0]             layer_rows,
  output logic [31:0]             layer_cols,
  output logic [ADDR_WIDTH-1:0]   layer_base,
  output logic                    busy,
  output logic                    load_done,
  output logic                    error
);

  localparam int BPW = WEIGHT_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WGT,
`ifdef MODEL_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef MODEL_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t r_state, w_next;

  logic [63:0]             r_hdr;
  logic [2:0]              r_hcnt;
  logic [2:0]              r_wbyte;
  logic [WEIGHT_WIDTH-1:0] r_wacc;
  logic [31:0]             r_row, r_col;
  logic [ADDR_WIDTH:0]     r_addr;
  logic [7:0]              r_num_layers;
  logic [7:0]              r_layer_idx;
  logic [31:0]             r_layer_rows, r_layer_cols;
  logic [ADDR_WIDTH-1:0]   r_layer_base;
  logic                    r_hdr_valid;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [WEIGHT_WIDTH-1:0] r_wr_data;
  logic [7:0]              r_xor;

  logic                    w_busy, w_accept, w_start;
  logic [63:0]             w_hdr_next;
  logic                    w_hdr_last, w_hdr_ok;
  logic [WEIGHT_WIDTH-1:0] w_wnext;
  logic                    w_wgt_done, w_ovf;
  logic                    w_layer_last, w_last_layer;

  // Handshake: a byte transfers on a rising clk edge where s_valid && s_ready; s_ready is
  // a pure function of state (high only while parsing) and never depends on s_valid.
  assign w_busy   = (r_state == S_HDR) || (r_state == S_WGT)
`ifdef MODEL_CHECKSUM_EN
                 || (r_state == S_CHK)
`endif
                 ;
  assign w_accept = s_valid && w_busy;
  assign w_start  = start_load && !w_busy;

  // Header bytes shift in from the top, so after 8 bytes rows sit in [31:0] and cols in [63:32].
  assign w_hdr_next = {s_data, r_hdr[63:8]};
  assign w_hdr_last = w_accept && (r_state == S_HDR) && (r_hcnt == 3'd7);
  assign w_hdr_ok   = (w_hdr_next[31:0] != 32'd0) && (w_hdr_next[63:32] != 32'd0) &&
                      (w_hdr_next[31:0] <= 32'(MAX_NEURONS)) &&
                      (w_hdr_next[63:32] <= 32'(MAX_NEURONS));

  assign w_wnext      = WEIGHT_WIDTH'({s_data, r_wacc} >> 8);
  assign w_wgt_done   = w_accept && (r_state == S_WGT) && (r_wbyte == 3'(BPW - 1));
  assign w_ovf        = r_addr[ADDR_WIDTH];
  assign w_layer_last = w_wgt_done && (r_col == r_layer_cols - 32'd1) &&
                        (r_row == r_layer_rows - 32'd1);
  assign w_last_layer = (r_layer_idx + 8'd1) == r_num_layers;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_load) begin
          if (num_layers == 8'd0)                 w_next = S_FIN;
          else if (num_layers > 8'(MAX_LAYERS))   w_next = S_ERR;
          else                                    w_next = S_HDR;
        end
      end
      S_HDR: begin
        if (w_hdr_last) w_next = w_hdr_ok ? S_WGT : S_ERR;
      end
      S_WGT: begin
        if (w_wgt_done) begin
          if (w_ovf)             w_next = S_ERR;
          else if (w_layer_last) w_next = w_last_layer ? S_FIN : S_HDR;
        end
      end
`ifdef MODEL_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_next = (s_data == r_xor) ? S_DONE : S_ERR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr        <= '0;
      r_hcnt       <= '0;
      r_wbyte      <= '0;
      r_wacc       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_addr       <= '0;
      r_num_layers <= '0;
      r_layer_idx  <= '0;
      r_layer_rows <= '0;
      r_layer_cols <= '0;
      r_layer_base <= '0;
      r_hdr_valid  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_xor        <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_hdr_valid <= 1'b0;
      if (w_start) begin
        r_num_layers <= num_layers;
        r_layer_idx  <= '0;
        r_addr       <= '0;
        r_hcnt       <= '0;
        r_wbyte      <= '0;
        r_row        <= '0;
        r_col        <= '0;
        r_xor        <= '0;
      end else if (w_accept) begin
        r_xor <= r_xor ^ s_data;
        if (r_state == S_HDR) begin
          r_hdr  <= w_hdr_next;
          r_hcnt <= r_hcnt + 3'd1;
          if (w_hdr_last && w_hdr_ok) begin
            r_layer_rows <= w_hdr_next[31:0];
            r_layer_cols <= w_hdr_next[63:32];
            r_layer_base <= r_addr[ADDR_WIDTH-1:0];
            r_hdr_valid  <= 1'b1;
            r_row        <= '0;
            r_col        <= '0;
            r_wbyte      <= '0;
          end
        end else if (r_state == S_WGT) begin
          if (w_wgt_done) begin
            r_wbyte <= '0;
            // An address past the top of RAM is never written; the FSM goes to ERR instead.
            if (!w_ovf) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr[ADDR_WIDTH-1:0];
              r_wr_data <= w_wnext;
              r_addr    <= r_addr + (ADDR_WIDTH+1)'(1);
            end
            if (r_col == r_layer_cols - 32'd1) begin
              r_col <= '0;
              r_row <= r_row + 32'd1;
            end else begin
              r_col <= r_col + 32'd1;
            end
            if (w_layer_last && !w_last_layer) r_layer_idx <= r_layer_idx + 8'd1;
          end else begin
            r_wacc  <= w_wnext;
            r_wbyte <= r_wbyte + 3'd1;
          end
        end
      end
    end
  end

  assign s_ready         = w_busy;
  assign busy            = w_busy;
  assign load_done       = (r_state == S_DONE);
  assign error           = (r_state == S_ERR);
  assign wr_en           = r_wr_en;
  assign wr_addr         = r_wr_addr;
  assign wr_data         = r_wr_data;
  assign layer_hdr_valid = r_hdr_valid;
  assign layer_idx       = r_layer_idx;
  assign layer_rows      = r_layer_rows;
  assign layer_cols      = r_layer_cols;
  assign layer_base      = r_layer_base;

endmodule

// File: tb/tb_model_stream_loader.sv
// Bench for model_stream_loader: table of directed loads plus hand sequences for reset, boundary and 16-bit weights.
module tb_model_stream_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_load, start16;
  logic [7:0]  num_layers;
  logic        s_valid, v16;
  logic [7:0]  s_data;

  logic        s_ready, wr_en, layer_hdr_valid, busy, load_done, error;
  logic [15:0] wr_addr, layer_base;
  logic [7:0]  wr_data, layer_idx;
  logic [31:0] layer_rows, layer_cols;

  logic        r16, we16, hv16, b16, d16, e16;
  logic [15:0] wa16, lb16, wd16;
  logic [7:0]  li16;
  logic [31:0] lr16, lc16;

  model_stream_loader #(.WEIGHT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .num_layers(num_layers),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .layer_hdr_valid(layer_hdr_valid), .layer_idx(layer_idx), .layer_rows(layer_rows),
    .layer_cols(layer_cols), .layer_base(layer_base),
    .busy(busy), .load_done(load_done), .error(error)
  );

  model_stream_loader #(.WEIGHT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_load(start16), .num_layers(num_layers),
    .s_valid(v16), .s_ready(r16), .s_data(s_data),
    .wr_en(we16), .wr_addr(wa16), .wr_data(wd16),
    .layer_hdr_valid(hv16), .layer_idx(li16), .layer_rows(lr16),
    .layer_cols(lc16), .layer_base(lb16),
    .busy(b16), .load_done(d16), .error(e16)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_q[$];
  logic [31:0] exp16_q[$];

  int          hdr_cnt = 0;
  logic [7:0]  h_idx;
  logic [31:0] h_rows, h_cols;
  logic [15:0] h_base;
  logic        acc_d = 1'b0;
  logic        acc16_d = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must follow an accepted byte and match the head of the expected queue.
  always @(posedge clk) begin
    acc_d   <= s_valid && s_ready;
    acc16_d <= v16 && r16;
  end

  always @(negedge clk) begin
    if (wr_en) begin
      chk("wr_after_accept", 64'(acc_d), 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
      end
    end
    if (we16) begin
      chk("wr16_after_accept", 64'(acc16_d), 64'd1);
      if (exp16_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_wr16: got addr %0h data %0h expected no write", wa16, wd16);
      end else begin
        chk("wr16_addr_data", 64'({wa16, wd16}), 64'(exp16_q.pop_front()));
      end
    end
    if (layer_hdr_valid) begin
      hdr_cnt++;
      h_idx  = layer_idx;
      h_rows = layer_rows;
      h_cols = layer_cols;
      h_base = layer_base;
    end
  end

  typedef struct {
    logic [7:0]   nl;
    int           n;
    logic [255:0] bytes;
    int           gap;
    int           nw;
    logic [95:0]  wd;
    logic         done;
    logic         err;
    int           nh;
    logic [7:0]   hidx;
    logic [31:0]  hrows;
    logic [31:0]  hcols;
    logic [15:0]  hbase;
  } vec_t;

  vec_t vt[8];

  function automatic vec_t mk(input logic [7:0] nl, input int n, input logic [255:0] bytes,
                              input int gap, input int nw, input logic [95:0] wd,
                              input logic done, input logic err, input int nh,
                              input logic [7:0] hidx, input logic [31:0] hrows,
                              input logic [31:0] hcols, input logic [15:0] hbase);
    vec_t v;
    v.nl = nl; v.n = n; v.bytes = bytes; v.gap = gap; v.nw = nw; v.wd = wd;
    v.done = done; v.err = err; v.nh = nh; v.hidx = hidx; v.hrows = hrows;
    v.hcols = hcols; v.hbase = hbase;
    return v;
  endfunction

  function automatic logic [7:0] xor_stream(input logic [255:0] lit, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ lit[8*(n-1-i) +: 8];
    return x;
  endfunction

  task automatic pulse_start(input bit sel, input logic [7:0] nl);
    @(posedge clk); #1;
    num_layers = nl;
    if (sel) start16 = 1'b1; else start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    start16    = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap, output bit ok);
    logic rdy;
    repeat (gap) begin @(posedge clk); #1; end
    s_data = b;
    if (sel) v16 = 1'b1; else s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      rdy = sel ? r16 : s_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    s_valid = 1'b0;
    v16     = 1'b0;
  endtask

  task automatic send_stream(input bit sel, input logic [255:0] lit, input int n, input int gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_byte(sel, lit[8*(n-1-i) +: 8], gap, ok);
      chk("byte_accept", 64'(ok), 64'd1);
      if (!ok) break;
    end
  endtask

  task automatic wait_idle(input bit sel);
    for (int t = 0; t < 50; t++) begin
      if (!(sel ? b16 : busy)) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 64'(sel ? b16 : busy), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit ok;
    hdr_cnt = 0;
    for (int i = 0; i < v.nw; i++) exp_q.push_back({16'(i), v.wd[8*(v.nw-1-i) +: 8]});
    pulse_start(1'b0, v.nl);
    if (v.nl != 8'd0 && v.nl <= 8'd10)
      chk("start_state", 64'({busy, load_done, error}), 64'b100);
    send_stream(1'b0, v.bytes, v.n, v.gap);
`ifdef MODEL_CHECKSUM_EN
    if (v.done) begin
      send_byte(1'b0, xor_stream(v.bytes, v.n), v.gap, ok);
      chk("chk_byte_accept", 64'(ok), 64'd1);
    end
`endif
    wait_idle(1'b0);
    $display("vector %0d: done=%0b error=%0b headers=%0d", id, load_done, error, hdr_cnt);
    chk("load_done", 64'(load_done), 64'(v.done));
    chk("error", 64'(error), 64'(v.err));
    chk("s_ready_idle", 64'(s_ready), 64'd0);
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    chk("hdr_count", 64'(hdr_cnt), 64'(v.nh));
    if (v.nh > 0) begin
      chk("hdr_idx", 64'(h_idx), 64'(v.hidx));
      chk("hdr_rows", 64'(h_rows), 64'(v.hrows));
      chk("hdr_cols", 64'(h_cols), 64'(v.hcols));
      chk("hdr_base", 64'(h_base), 64'(v.hbase));
    end
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    start_load = 1'b0; start16 = 1'b0; num_layers = 8'd0;
    s_valid = 1'b0; v16 = 1'b0; s_data = 8'd0;

    vt[0] = mk(8'd1, 14, 256'h02000000_03000000_112233445566, 0, 6, 96'h112233445566,
               1'b1, 1'b0, 1, 8'd0, 32'd2, 32'd3, 16'd0);
    vt[1] = mk(8'd2, 22, 256'h01000000_02000000_AABB_02000000_02000000_01020304, 0, 6,
               96'hAABB01020304, 1'b1, 1'b0, 2, 8'd1, 32'd2, 32'd2, 16'd2);
    vt[2] = mk(8'd1, 14, 256'h02000000_03000000_112233445566, 3, 6, 96'h112233445566,
               1'b1, 1'b0, 1, 8'd0, 32'd2, 32'd3, 16'd0);
    vt[3] = mk(8'd1, 8, 256'h00000000_03000000, 0, 0, 96'h0, 1'b0, 1'b1, 0, 8'd0, 32'd0, 32'd0, 16'd0);
    vt[4] = mk(8'd1, 8, 256'h02000000_01040000, 0, 0, 96'h0, 1'b0, 1'b1, 0, 8'd0, 32'd0, 32'd0, 16'd0);
    vt[5] = mk(8'd0, 0, 256'h0, 0, 0, 96'h0, 1'b1, 1'b0, 0, 8'd0, 32'd0, 32'd0, 16'd0);
    vt[6] = mk(8'd11, 0, 256'h0, 0, 0, 96'h0, 1'b0, 1'b1, 0, 8'd0, 32'd0, 32'd0, 16'd0);
    vt[7] = mk(8'd2, 17, 256'h01000000_01000000_5A_01040000_01000000, 0, 1, 96'h5A,
               1'b0, 1'b1, 1, 8'd0, 32'd1, 32'd1, 16'd0);

    repeat (2) begin @(posedge clk); #1; end
    chk("reset_flags", 64'({busy, s_ready, wr_en, load_done, error, layer_hdr_valid}), 64'd0);
    chk("reset_fields", 64'({layer_idx, wr_addr, layer_base}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Mid-load reset after the third weight, with an ignored start_load while busy.
    hdr_cnt = 0;
    exp_q.push_back({16'd0, 8'h11});
    exp_q.push_back({16'd1, 8'h22});
    exp_q.push_back({16'd2, 8'h33});
    pulse_start(1'b0, 8'd1);
    send_stream(1'b0, 256'h02000000_03000000, 8, 0);
    pulse_start(1'b0, 8'd5);
    chk("busy_ignore_start", 64'({busy, layer_idx, layer_rows}), {31'd0, 1'b1, 8'd0, 32'd2});
    send_stream(1'b0, 256'h112233, 3, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_reset_writes", 64'(exp_q.size()), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_flags", 64'({busy, s_ready, wr_en, load_done, error, layer_hdr_valid}), 64'd0);
    chk("midreset_fields", 64'({layer_rows, wr_addr, layer_base}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(vt[0], 8);

    // Largest legal dimension: 1024 rows of one column.
    hdr_cnt = 0;
    for (int i = 0; i < 1024; i++) exp_q.push_back({16'(i), 8'(i)});
    pulse_start(1'b0, 8'd1);
    send_stream(1'b0, 256'h00040000_01000000, 8, 0);
    begin
      logic [7:0] x;
      x = 8'h04 ^ 8'h01;
      for (int i = 0; i < 1024; i++) begin
        send_byte(1'b0, 8'(i), 0, ok);
        x = x ^ 8'(i);
        if (!ok) break;
      end
      chk("big_accept", 64'(ok), 64'd1);
`ifdef MODEL_CHECKSUM_EN
      send_byte(1'b0, x, 0, ok);
`endif
    end
    wait_idle(1'b0);
    chk("big_done", 64'({load_done, error}), 64'b10);
    chk("big_rows", 64'(h_rows), 64'd1024);
    chk("big_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

`ifdef MODEL_CHECKSUM_EN
    // XOR of the test-1 stream is 0x76; a zero trailer must be rejected after all writes.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) exp_q.push_back({16'(i), vt[0].wd[8*(5-i) +: 8]});
      pulse_start(1'b0, 8'd1);
      send_stream(1'b0, vt[0].bytes, 14, 0);
      send_byte(1'b0, (k == 0) ? 8'h76 : 8'h00, 0, ok);
      wait_idle(1'b0);
      chk("chk_result", 64'({load_done, error}), (k == 0) ? 64'b10 : 64'b01);
      chk("chk_writes_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
`endif

    // 16-bit weights assembled little-endian.
    exp16_q.push_back({16'd0, 16'h2211});
    exp16_q.push_back({16'd1, 16'h4433});
    exp16_q.push_back({16'd2, 16'h6655});
    exp16_q.push_back({16'd3, 16'h8877});
    exp16_q.push_back({16'd4, 16'hAA99});
    exp16_q.push_back({16'd5, 16'hCCBB});
    pulse_start(1'b1, 8'd1);
    send_stream(1'b1, 256'h02000000_03000000_112233445566778899AABBCC, 20, 0);
`ifdef MODEL_CHECKSUM_EN
    send_byte(1'b1, xor_stream(256'h02000000_03000000_112233445566778899AABBCC, 20), 0, ok);
`endif
    wait_idle(1'b1);
    chk("w16_done", 64'({d16, e16}), 64'b10);
    chk("w16_hdr", 64'({lr16, lc16}), {32'd2, 32'd3});
    chk("w16_writes_left", 64'(exp16_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
